rr_reg_write_arbiter: RTL

- Round-robin write arbiter that shares one WIDTH-bit storage register among NREQ requesters.
- Each requester presents a request and a data word. The arbiter grants one requester at a time and drives the register's clock-enable and data.
- The shared register is held internally and exposed as q.
- Sits between producer blocks and the shared register-based datapath; the only writer of that register.

---
 rtl/rr_reg_write_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rr_reg_write_arbiter.sv
// rr_reg_write_arbiter
//
// Round-robin write arbiter that owns one shared WIDTH-bit register. Each
// requester raises req[i] with its data word on din[i*WIDTH +: WIDTH]. The
// arbiter picks one winner per IDLE edge, drives a one-cycle grant/write
// enable with the captured data, and commits that data into the shared
// register on the following (GRANT) edge.
//
// Handshake: a requester holds req[i] and its din word stable until it sees
// gnt[i] high. gnt[i] high for one cycle means its word has been captured.
// To make a single write, it drops req[i] during that gnt cycle. req still
// high at the next IDLE edge is a new request.
//
// Ports:
//   clk      rising-edge clock
//   clr      asynchronous active-high reset
//   req      per-requester write request (level)
//   din      packed requester data, requester i at [i*WIDTH +: WIDTH]
//   gnt      registered one-hot grant, high one cycle per write
//   ce       shared register write enable (|gnt)
//   d        data being written, held until the next grant
//   q        shared register contents
//   busy     high while the FSM is in GRANT (exposes the FSM state)
//   last_id  index of the most recently completed write
module rr_reg_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     din,
    output logic [NREQ-1:0]           gnt,
    output logic                      ce,
    output logic [WIDTH-1:0]          d,
    output logic [WIDTH-1:0]          q,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   last_id
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   win_q, win_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] q_q, q_d;

    // Round-robin search starting at ptr_q. cand is one bit wider so the
    // wrap works for requester counts that are not a power of two.
    logic             found;
    logic [IDW-1:0]   win;
    logic [IDW:0]     cand;
    logic [WIDTH-1:0] win_data;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_data = din[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        last_d  = last_q;
        gnt_d   = '0;
        d_d     = d_q;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = NREQ'(1) << win;
                    d_d     = win_data;
                    win_d   = win;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Commit the captured word; req/din are not looked at here.
                q_d     = d_q;
                last_d  = win_q;
                ptr_d   = (win_q == IDW'(NREQ-1)) ? '0 : win_q + IDW'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset during GRANT drops the pending write: q clears instead of taking d.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            last_q  <= '0;
            gnt_q   <= '0;
            d_q     <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            d_q     <= d_d;
            q_q     <= q_d;
        end
    end

    assign gnt     = gnt_q;
    assign ce      = |gnt_q;
    assign d       = d_q;
    assign q       = q_q;
    assign busy    = (state_q == GRANT);
    assign last_id = last_q;

endmodule
